// File: rtl/banked_mem_pkg.sv
// Shared definitions for the banked memory: FSM state encoding and a
// constant-evaluable clog2 used to size the bank select.
package banked_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/banked_mem_bank.sv
// Single-port storage bank with byte-lane writes and a registered,
// read-before-write output.
module mem_bank #(
    parameter int AW     = 21,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[idx];
        if (we) begin
            for (int k = 0; k < DATA_W/8; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/banked_mem.sv
// Parametrised banked word memory: post-reset zero-fill sweep, byte-lane
// writes, one-cycle registered reads and error strobes for unpopulated banks.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zero-fill sweep (or single pass-through cycle), ready low
//   ST_RUN  | accepting one request per cycle until the next reset
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int NUM_BANKS      = 8,
    parameter int BANK_AW        = 21,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1,
    localparam int SEL_W  = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1,
    localparam int ADDR_W = SEL_W + BANK_AW,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dira,
    input  logic [DATA_W-1:0] write_data,
    input  logic [BE_W-1:0]   byte_en,
    input  logic              memwrite,
    input  logic              memread,
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] out,
    output logic              err
);

    state_t             state_q, state_d;
    logic [BANK_AW-1:0] cnt_q;
    logic               sweep_we;
    logic [SEL_W-1:0]   sel, sel_q;
    logic               in_range, oor_q;
    logic               accept;
    logic [DATA_W-1:0]  out_hold_q;
    logic [DATA_W-1:0]  rd_word;
    logic [BANK_AW-1:0] bank_idx;
    logic [BE_W-1:0]    bank_be;
    logic [DATA_W-1:0]  bank_wdata;
    logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

    always_comb begin
        state_d  = state_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    sweep_we = 1'b1;
                    if (cnt_q == '1) state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (sweep_we) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ready    = (state_q == ST_RUN);
    assign sel      = dira[ADDR_W-1:BANK_AW];
    assign in_range = ({1'b0, sel} < (SEL_W + 1)'(NUM_BANKS));
    assign accept   = ready & (memread | memwrite);

    // The sweep shares the bank ports; ready is low throughout, so requests never collide with it.
    assign bank_idx   = sweep_we ? cnt_q : dira[BANK_AW-1:0];
    assign bank_be    = sweep_we ? {BE_W{1'b1}} : byte_en;
    assign bank_wdata = sweep_we ? '0 : write_data;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic hit;
        assign hit = (sel == SEL_W'(b));

        mem_bank #(
            .AW     (BANK_AW),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .we    (sweep_we | (ready & memwrite & hit)),
            .be    (bank_be),
            .idx   (bank_idx),
            .wdata (bank_wdata),
            .re    (ready & memread & hit),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid   <= 1'b0;
            err        <= 1'b0;
            sel_q      <= '0;
            oor_q      <= 1'b0;
            out_hold_q <= '0;
        end else begin
            rd_valid   <= accept & memread;
            err        <= accept & ~in_range;
            sel_q      <= sel;
            oor_q      <= ~in_range;
            out_hold_q <= out;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel_q == SEL_W'(b)) rd_word = bank_rdata[b];
        end
    end

    // Between reads the last result is replayed from out_hold_q.
    always_comb begin
        out = out_hold_q;
        if (rd_valid) out = oor_q ? '0 : rd_word;
    end

endmodule

// File: tb/tb_banked_mem.sv
// Self-checking bench for banked_mem (6 banks x 16 words x 32 bits) against a
// flat word-array model with an edge-count notion of readiness.
module tb_banked_mem;

    logic        clk;
    logic        rst_n;
    logic [6:0]  dira;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic        memwrite;
    logic        memread;
    logic        ready;
    logic        rd_valid;
    logic [31:0] out;
    logic        err;

    banked_mem #(
        .NUM_BANKS      (6),
        .BANK_AW        (4),
        .DATA_W         (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dira       (dira),
        .write_data (write_data),
        .byte_en    (byte_en),
        .memwrite   (memwrite),
        .memread    (memread),
        .ready      (ready),
        .rd_valid   (rd_valid),
        .out        (out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          edges;
    logic [31:0] model [128];
    logic [31:0] out_exp;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model[i] = 32'h0;
    endtask

    // One clock of stimulus; expectations come from the model state before the edge.
    task automatic step(input logic rd, input logic wr, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        logic rdy, oor, exp_rv, exp_err;
        memread    = rd;
        memwrite   = wr;
        dira       = a;
        write_data = d;
        byte_en    = be;
        @(posedge clk);
        rdy     = (edges >= 16);
        edges++;
        oor     = (a[6:4] >= 3'd6);
        exp_rv  = rdy & rd;
        exp_err = rdy & (rd | wr) & oor;
        if (exp_rv) out_exp = oor ? 32'h0 : model[a];
        if (rdy && wr && !oor) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
        end
        @(negedge clk);
        check("ready", {31'b0, ready}, {31'b0, edges >= 16});
        check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rv});
        check("err", {31'b0, err}, {31'b0, exp_err});
        check("out", out, out_exp);
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_ready"}, {31'b0, ready}, 32'h0);
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'h0);
        check({tag, "_err"}, {31'b0, err}, 32'h0);
        check({tag, "_out"}, out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        edges   = 0;
        out_exp = 32'h0;
        clear_model();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edges       = 0;
        out_exp     = 32'h0;
        clear_model();
        rst_n      = 1'b0;
        dira       = '0;
        write_data = '0;
        byte_en    = '0;
        memwrite   = 1'b0;
        memread    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_out", out, 32'h0);
        rst_n = 1'b1;

        // Reads hammered through the sweep: nothing until ready, then 0x7F (unpopulated bank).
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 7'h7F, 32'h0, 4'h0);

        step(1'b0, 1'b1, 7'h35, 32'hDEADBEEF, 4'hF);
        step(1'b1, 1'b0, 7'h35, 32'h0, 4'h0);
        check("basic_rd_35", out, 32'hDEADBEEF);
        step(1'b1, 1'b0, 7'h25, 32'h0, 4'h0);
        check("basic_rd_25", out, 32'h00000000);
        step(1'b0, 1'b1, 7'h35, 32'h11223344, 4'b0101);
        step(1'b1, 1'b0, 7'h35, 32'h0, 4'h0);
        check("lanes_rd_35", out, 32'hDE22BE44);
        step(1'b1, 1'b1, 7'h35, 32'hCAFEF00D, 4'hF);
        check("swap_old", out, 32'hDE22BE44);
        step(1'b1, 1'b0, 7'h35, 32'h0, 4'h0);
        check("swap_new", out, 32'hCAFEF00D);
        step(1'b0, 1'b0, 7'h00, 32'h0, 4'h0);
        check("idle_hold", out, 32'hCAFEF00D);
        step(1'b1, 1'b0, 7'h62, 32'h0, 4'h0);
        check("oor_rd_err", {31'b0, err}, 32'h1);
        step(1'b0, 1'b1, 7'h7A, 32'h12345678, 4'hF);
        check("oor_wr_rv", {31'b0, rd_valid}, 32'h0);
        step(1'b1, 1'b0, 7'h0A, 32'h0, 4'h0);
        check("bank0_rd_0A", out, 32'h0);
        step(1'b1, 1'b1, 7'h6A, 32'h55555555, 4'hF);
        step(1'b1, 1'b0, 7'h0A, 32'h0, 4'h0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                 $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of the sweep, at index 9.
        reset_now("rst_run");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 7'h13, 32'hA5A5A5A5, 4'hF);
        reset_now("rst_sweep");
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 7'h13, 32'h0, 4'h0);
        check("after_sweep_rst", {31'b0, ready}, 32'h1);

        // Reset while a read result is on the output.
        step(1'b0, 1'b1, 7'h21, 32'h87654321, 4'hF);
        step(1'b1, 1'b0, 7'h21, 32'h0, 4'h0);
        check("pending_rd_out", out, 32'h87654321);
        reset_now("rst_pending");
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 7'h21, 32'h0, 4'h0);
        check("after_pending_rst", out, 32'h0);

        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                 $urandom, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
